// File: rtl/ysyx_24120013_ifu.sv
// Instruction fetch: holds the PC, keeps one imem read in flight, and hands {inst, pc} to decode.
// Latency: inst_valid rises the cycle after imem_rsp_valid; 3 cycles/inst with 1-cycle memory.
// Backpressure: decode stalls via inst_ready (HOLD keeps outputs stable); imem via imem_req_ready.
module ysyx_24120013_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_exc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    kill;

    logic                    misaligned;
    logic                    req_fire;
    logic                    rsp_in_wait;
    logic                    capture_fault;
    logic                    capture_rsp;

    assign misaligned  = |pc[1:0];
    assign req_fire    = imem_req_valid & imem_req_ready;
    assign rsp_in_wait = (state == S_WAIT) & imem_rsp_valid;

    // A misaligned PC never reaches memory; it becomes a faulting instruction
    // unless a redirect retargets the PC in the same cycle.
    assign capture_fault = (state == S_REQ) & misaligned & ~redirect_valid;
    // Responses for killed fetches, or racing a redirect, are dropped.
    assign capture_rsp   = rsp_in_wait & ~kill & ~redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_REQ: begin
                if (req_fire) begin
                    state_nxt = S_WAIT;
                end else if (capture_fault) begin
                    state_nxt = S_HOLD;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = capture_rsp ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = rst & (state == S_REQ) & ~misaligned;
        imem_req_addr  = pc;
        inst_valid     = (state == S_HOLD);
    end

    // Redirect wins over the sequential advance, even when decode accepts in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if ((state == S_HOLD) && inst_ready) begin
            pc <= pc + ADDR_WIDTH'(4);
        end
    end

    // kill marks the single in-flight request as stale; only its response clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill <= 1'b0;
        end else if (state == S_WAIT) begin
            if (imem_rsp_valid) begin
                kill <= 1'b0;
            end else if (redirect_valid) begin
                kill <= 1'b1;
            end
        end else if ((state == S_REQ) && req_fire && redirect_valid) begin
            kill <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst     <= '0;
            inst_pc  <= '0;
            inst_exc <= 1'b0;
        end else if (capture_fault) begin
            inst     <= '0;
            inst_pc  <= pc;
            inst_exc <= 1'b1;
        end else if (capture_rsp) begin
            inst     <= imem_rsp_err ? '0 : imem_rsp_data;
            inst_pc  <= pc;
            inst_exc <= imem_rsp_err;
        end
    end

endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// Directed bench for the fetch unit; inputs driven and outputs sampled on the falling edge.
module tb_ysyx_24120013_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_exc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    ysyx_24120013_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_exc       (inst_exc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic accept_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
        checks++; if (inst_exc !== 1'b0) begin errors++; $display("FAIL reset_inst_exc: got %b expected 0", inst_exc); end
    endtask

    task automatic test_basic_fetch();
        inst_ready = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_first_req: got %b expected 1", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL basic_addr0: got %h expected 80000000", imem_req_addr); end
        accept_req();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_no_req_wait: got %b expected 0", imem_req_valid); end
        respond(32'h0000_0013, 1'b0);
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid0: got %b expected 1", inst_valid); end
        checks++; if (inst !== 32'h0000_0013) begin errors++; $display("FAIL basic_inst0: got %h expected 00000013", inst); end
        checks++; if (inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_pc0: got %h expected 80000000", inst_pc); end
        checks++; if (inst_exc !== 1'b0) begin errors++; $display("FAIL basic_exc0: got %b expected 0", inst_exc); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin errors++; $display("FAIL basic_req1: got valid %b addr %h expected 1 80000004", imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0010_0073, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0073) begin errors++; $display("FAIL basic_inst1: got valid %b inst %h expected 1 00100073", inst_valid, inst); end
        checks++; if (inst_pc !== 32'h8000_0004) begin errors++; $display("FAIL basic_pc1: got %h expected 80000004", inst_pc); end
        step();
    endtask

    task automatic test_hold_stall();
        inst_ready = 1'b0;
        checks++; if (imem_req_addr !== 32'h8000_0008) begin errors++; $display("FAIL stall_addr: got %h expected 80000008", imem_req_addr); end
        accept_req();
        respond(32'h1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || inst_pc !== 32'h8000_0008 || inst_exc !== 1'b0 || imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h exc=%b req=%b expected 1 12345678 80000008 0 0", i, inst_valid, inst, inst_pc, inst_exc, imem_req_valid);
            end
            step();
        end
        inst_ready = 1'b1;
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C) begin errors++; $display("FAIL stall_next_req: got valid %b addr %h expected 1 8000000c", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        accept_req();
        redirect(32'h8000_0100);
        for (int i = 0; i < 2; i++) begin
            checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_quiet[%0d]: got valid %b req %b expected 0 0", i, inst_valid, imem_req_valid); end
            step();
        end
        respond(32'h0BAD_0BAD, 1'b0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_discard: got inst_valid %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin errors++; $display("FAIL rdw_req: got valid %b addr %h expected 1 80000100", imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0000_0093, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0093 || inst_pc !== 32'h8000_0100) begin errors++; $display("FAIL rdw_deliver: got v=%b inst=%h pc=%h expected 1 00000093 80000100", inst_valid, inst, inst_pc); end
        step();
    endtask

    task automatic test_redirect_same_cycle();
        checks++; if (imem_req_addr !== 32'h8000_0104) begin errors++; $display("FAIL rsc_addr: got %h expected 80000104", imem_req_addr); end
        accept_req();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        redirect(32'h8000_0200);
        imem_rsp_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rsc_discard: got inst_valid %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin errors++; $display("FAIL rsc_req: got valid %b addr %h expected 1 80000200", imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0000_0113, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0113 || inst_pc !== 32'h8000_0200) begin errors++; $display("FAIL rsc_deliver: got v=%b inst=%h pc=%h expected 1 00000113 80000200", inst_valid, inst, inst_pc); end
        step();

        imem_req_ready = 1'b1;
        redirect(32'h8000_0300);
        imem_req_ready = 1'b0;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rhs_wait: got req %b expected 0", imem_req_valid); end
        respond(32'h0BAD_0BAD, 1'b0);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rhs_discard: got inst_valid %b expected 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300) begin errors++; $display("FAIL rhs_req: got valid %b addr %h expected 1 80000300", imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0000_0193, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0193 || inst_pc !== 32'h8000_0300) begin errors++; $display("FAIL rhs_deliver: got v=%b inst=%h pc=%h expected 1 00000193 80000300", inst_valid, inst, inst_pc); end
        step();
    endtask

    task automatic test_faults();
        redirect(32'h8000_0102);
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_no_req: got %b expected 0", imem_req_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_exc !== 1'b1) begin errors++; $display("FAIL mis_exc: got valid %b exc %b expected 1 1", inst_valid, inst_exc); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h8000_0102) begin errors++; $display("FAIL mis_data: got inst %h pc %h expected 00000000 80000102", inst, inst_pc); end
        redirect(32'h8000_0400);
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0400) begin errors++; $display("FAIL hold_redirect: got v=%b req=%b addr=%h expected 0 1 80000400", inst_valid, imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'hFFFF_FFFF, 1'b1);
        checks++; if (inst_valid !== 1'b1 || inst_exc !== 1'b1 || inst !== 32'h0) begin errors++; $display("FAIL acc_fault: got v=%b exc=%b inst=%h expected 1 1 00000000", inst_valid, inst_exc, inst); end
        checks++; if (inst_pc !== 32'h8000_0400) begin errors++; $display("FAIL acc_fault_pc: got %h expected 80000400", inst_pc); end
        step();
    endtask

    task automatic test_reset_mid();
        checks++; if (imem_req_addr !== 32'h8000_0404) begin errors++; $display("FAIL rmid_addr: got %h expected 80000404", imem_req_addr); end
        accept_req();
        rst = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_exc !== 1'b0) begin errors++; $display("FAIL rmid_async: got req=%b v=%b pc=%h exc=%b expected 0 0 00000000 0", imem_req_valid, inst_valid, inst_pc, inst_exc); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rmid_restart: got valid %b addr %h expected 1 80000000", imem_req_valid, imem_req_addr); end
        step();
        respond(32'h0BAD_0BAD, 1'b0);
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rmid_stray: got v=%b req=%b addr=%h expected 0 1 80000000", inst_valid, imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0000_0013, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0013 || inst_pc !== 32'h8000_0000) begin errors++; $display("FAIL rmid_deliver: got v=%b inst=%h pc=%h expected 1 00000013 80000000", inst_valid, inst, inst_pc); end
        step();
    endtask

    task automatic test_wrap();
        redirect(32'hFFFF_FFFC);
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got valid %b addr %h expected 1 fffffffc", imem_req_valid, imem_req_addr); end
        accept_req();
        respond(32'h0000_0073, 1'b0);
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_inst: got v=%b pc=%h expected 1 fffffffc", inst_valid, inst_pc); end
        step();
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next: got valid %b addr %h expected 1 00000000", imem_req_valid, imem_req_addr); end
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_faults();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
